// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared widths for the hazard scoreboard (option macro: HAZARD_FORWARDING_EN)
`timescale 1ns/1ps
package hazard_scoreboard_pkg;

    localparam int LEN_INST_REG = 5;
    localparam int STALL_CNT_W  = 32;

    // Shadow-entry field widths: {valid, rd, reg_write, mem_read}
    localparam int SHADOW_VALID_W     = 1;
    localparam int SHADOW_REG_WRITE_W = 1;
    localparam int SHADOW_MEM_READ_W  = 1;

endpackage

// File: rtl/hazard_stage_reg.sv
// rtl/hazard_stage_reg.sv - one shadow pipeline entry tracking an in-flight register write
`timescale 1ns/1ps
module hazard_stage_reg
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = LEN_INST_REG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             load,
    input  logic             bubble,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_rd,
    input  logic             d_reg_write,
    input  logic             d_mem_read,
    output logic             q_valid,
    output logic [REG_W-1:0] q_rd,
    output logic             q_reg_write,
    output logic             q_mem_read
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_valid     <= 1'b0;
            q_rd        <= '0;
            q_reg_write <= 1'b0;
            q_mem_read  <= 1'b0;
        end else if (hold) begin
            q_valid     <= q_valid;
        end else if (bubble) begin
            q_valid     <= 1'b0;
            q_rd        <= '0;
            q_reg_write <= 1'b0;
            q_mem_read  <= 1'b0;
        end else if (load) begin
            q_valid     <= d_valid;
            q_rd        <= d_rd;
            q_reg_write <= d_reg_write;
            q_mem_read  <= d_mem_read;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW hazard detection, stall controls and stall-cycle counter
// Option macro HAZARD_FORWARDING_EN: defined = load-use only; undefined = no-forwarding build.
`timescale 1ns/1ps
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = LEN_INST_REG,
    parameter int CNT_W = STALL_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    output logic             stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic [REG_W-1:0] hazard_reg,
    output logic [CNT_W-1:0] stall_count
);

    logic             ex_valid, mem_valid, wb_valid;
    logic [REG_W-1:0] ex_rd, mem_rd, wb_rd;
    logic             ex_reg_write, mem_reg_write, wb_reg_write;
    logic             ex_mem_read, mem_mem_read, wb_mem_read;
    logic             ex_enter_bubble;
    logic             wb_unused;

    // The ID instruction only enters EX when it actually advances.
    assign ex_enter_bubble = ~(id_valid & ~stall & ~flush);

    hazard_stage_reg #(.REG_W(REG_W)) u_ex (
        .clk(clk), .rst_n(rst_n), .hold(freeze), .load(1'b1), .bubble(ex_enter_bubble),
        .d_valid(id_valid), .d_rd(id_rd), .d_reg_write(id_reg_write), .d_mem_read(id_mem_read),
        .q_valid(ex_valid), .q_rd(ex_rd), .q_reg_write(ex_reg_write), .q_mem_read(ex_mem_read)
    );

    hazard_stage_reg #(.REG_W(REG_W)) u_mem (
        .clk(clk), .rst_n(rst_n), .hold(freeze), .load(1'b1), .bubble(1'b0),
        .d_valid(ex_valid), .d_rd(ex_rd), .d_reg_write(ex_reg_write), .d_mem_read(ex_mem_read),
        .q_valid(mem_valid), .q_rd(mem_rd), .q_reg_write(mem_reg_write), .q_mem_read(mem_mem_read)
    );

    hazard_stage_reg #(.REG_W(REG_W)) u_wb (
        .clk(clk), .rst_n(rst_n), .hold(freeze), .load(1'b1), .bubble(1'b0),
        .d_valid(mem_valid), .d_rd(mem_rd), .d_reg_write(mem_reg_write), .d_mem_read(mem_mem_read),
        .q_valid(wb_valid), .q_rd(wb_rd), .q_reg_write(wb_reg_write), .q_mem_read(wb_mem_read)
    );

    // Write-before-read register file: the WB entry never causes a stall.
    assign wb_unused = ^{wb_valid, wb_rd, wb_reg_write, wb_mem_read};

    logic ex_writes, rs_ex, rt_ex;
    logic hz_rs_ex, hz_rt_ex, hz_rs_mem, hz_rt_mem;
    logic hazard_any;

    assign ex_writes = ex_valid & ex_reg_write & (ex_rd != '0);
    assign rs_ex     = id_use_rs & ex_writes & (ex_rd == id_rs);
    assign rt_ex     = id_use_rt & ex_writes & (ex_rd == id_rt);

`ifdef HAZARD_FORWARDING_EN
    assign hz_rs_ex  = rs_ex & ex_mem_read;
    assign hz_rt_ex  = rt_ex & ex_mem_read;
    assign hz_rs_mem = 1'b0;
    assign hz_rt_mem = 1'b0;
`else
    logic mem_writes;
    assign mem_writes = mem_valid & mem_reg_write & (mem_rd != '0);
    assign hz_rs_ex   = rs_ex;
    assign hz_rt_ex   = rt_ex;
    assign hz_rs_mem  = id_use_rs & mem_writes & (mem_rd == id_rs);
    assign hz_rt_mem  = id_use_rt & mem_writes & (mem_rd == id_rt);
`endif

    assign hazard_any = hz_rs_ex | hz_rt_ex | hz_rs_mem | hz_rt_mem;

    always_comb begin
        stall        = 1'b0;
        hazard_reg   = '0;
        if (rst_n && id_valid && !flush && hazard_any) begin
            stall = 1'b1;
            // Youngest stage wins; within a stage rs beats rt.
            if (hz_rs_ex)       hazard_reg = id_rs;
            else if (hz_rt_ex)  hazard_reg = id_rt;
            else if (hz_rs_mem) hazard_reg = id_rs;
            else                hazard_reg = id_rt;
        end
        pc_write     = ~stall;
        if_id_write  = ~stall;
        id_ex_bubble = stall | flush | ~rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && !freeze && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Producer-side counterpart of the forwarding unit.
- Tracks in-flight register writes in a shadow copy of the ID/EX, EX/MEM and MEM/WB stages.
- Detects RAW hazards that forwarding cannot cover and issues the stall/bubble controls for the PC, IF/ID and ID/EX registers.
- Sits in the decode stage, beside the forwarding unit, and keeps a saturating stall-cycle counter for profiling.

## Interface
Parameters:
- `REG_W`, default `LEN_INST_REG` (5): register-index width.
- `CNT_W`, default 32: stall-counter width.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `freeze`  in  1  global pipeline hold (memory wait); all state holds.
- `flush`  in  1  branch taken in EX. The instruction currently in ID is squashed.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`  in  REG_W  source registers of the ID instruction.
- `id_use_rs`, `id_use_rt`  in  1  the ID instruction actually reads rs / rt.
- `id_rd`  in  REG_W  destination register of the ID instruction, already muxed.
- `id_reg_write`  in  1  the ID instruction writes a register.
- `id_mem_read`  in  1  the ID instruction is a load.
- `stall`  out  1  RAW hazard present this cycle.
- `pc_write`  out  1  PC enable; equals ~stall.
- `if_id_write`  out  1  IF/ID enable; equals ~stall.
- `id_ex_bubble`  out  1  zero the ID/EX control bits; equals stall | flush.
- `hazard_reg`  out  REG_W  register causing the stall; 0 when no stall.
- `stall_count`  out  CNT_W  number of cycles in which `stall` was asserted.

## Operation
Shadow entries EX, MEM and WB each hold `{valid, rd, reg_write, mem_read}`.

Per-cycle update, when `rst_n` is high and `freeze` is low:
- WB <= MEM, and MEM <= EX.
- EX <= the ID instruction if `id_valid & ~stall & ~flush`; otherwise EX <= invalid (bubble).

A source register "matches" an entry when all of the following hold:
- the use bit is set;
- the entry is valid with `reg_write` set;
- `rd != 0`;
- `rd` equals the source.

Stall conditions (combinational, qualified by `id_valid & ~flush`) are defined under Configuration.

`hazard_reg`:
- Set to the rs match if rs matches; otherwise the rt match.
- When the rs and rt matches refer to different stages, the youngest stage (EX) is reported.

`stall_count`:
- Increments by 1 on each edge where `stall & ~freeze`.
- Saturates at all-ones.

Simultaneous events:
- `flush` and a hazard together: `stall` = 0 and `id_ex_bubble` = 1; the squashed instruction is never entered.
- `freeze`: all entries and the counter hold. Outputs are still computed from the held state.

## Timing
- `stall`, `pc_write`, `if_id_write`, `id_ex_bubble` and `hazard_reg` are combinational from the inputs and the current entries, with zero latency.
- On the edge where `rst_n` is low:
  - all entries become invalid and `stall_count` becomes 0;
  - while `rst_n` is low, the outputs are forced to `stall`=0, `pc_write`=1, `if_id_write`=1, `id_ex_bubble`=1 and `hazard_reg`=0.
- A reset during a stall clears the stall at the next edge. Pending writes are discarded.
- Load-use stall with forwarding: exactly 1 cycle. After it, the load is in MEM and the forwarding unit takes over.
- Stall without forwarding: at most 2 cycles. The register file is write-before-read, so a match in WB never stalls.

## Configuration
Macro `HAZARD_FORWARDING_EN`, placed in defs.v:
- Defined: `stall` asserts only when the EX entry matches and its `mem_read` is set (load-use).
- Undefined: `stall` asserts when either the EX or the MEM entry matches, regardless of `mem_read`. This is for the no-forwarding pipeline build.

## Structure
- Add `LEN_INST_REG` and the shadow-entry field widths, plus `HAZARD_FORWARDING_EN`, to the shared defs.v.
- One sub-module, `hazard_stage_reg`: a single shadow entry with `clk`, `rst_n`, hold, load and bubble controls.
  - It is instantiated three times.
  - The top level contains only the match/stall logic and the counter.

## Test plan
- With forwarding: `lw $8` in ID, then `add $9,$8,$10` in ID → exactly one cycle of `stall`=1 with `hazard_reg`=8. The next cycle `stall`=0, and `stall_count` = 1.
- With forwarding: `add $8`, then `sub $9,$8,$8` → no stall, `id_ex_bubble`=0.
- Without forwarding: `add $8`, then a dependent `or` → 2 cycles of stall. With one independent instruction between them → 1 cycle.
- Load into `$0`, then a use of `$0` → no stall. Load with a dependent instruction that has `id_use_rt`=0 and only rt matching → no stall.
- Load-use hazard with `flush`=1 in the same cycle → `stall`=0, `id_ex_bubble`=1. The EX entry becomes invalid.
- `freeze`=1 held for 3 cycles during a load-use stall → `stall` stays 1 and `stall_count` does not change. Asserting `rst_n`=0 mid-stall → the entries clear and `stall_count`=0 after one edge.
